// File: rtl/sbus_pkg.sv
// Shared register map, FSM state and bus-phase types for the SBUS multiplier master.
// SBUS_ONES_READ_EN adds the ones-count (L) read state.
package sbus_pkg;

    localparam logic [15:0] AddrA1   = 16'h037F;
    localparam logic [15:0] AddrA2   = 16'h0388;
    localparam logic [15:0] AddrCtrl = 16'h03A0;
    localparam logic [15:0] AddrStat = 16'h03A0;
    localparam logic [15:0] AddrW    = 16'h0390;
    localparam logic [15:0] AddrL    = 16'h0398;

    localparam logic [1:0] StatBusy = 2'b11;

    typedef enum logic [1:0] {
        PhSetup,
        PhStrobe,
        PhHold
    } phase_e;

    typedef enum logic [3:0] {
        StIdle,
        StWrA1,
        StWrA2,
        StWrGo,
        StGap,
        StPoll,
        StRdW,
`ifdef SBUS_ONES_READ_EN
        StRdL,
`endif
        StDone
    } state_e;

endpackage

// File: rtl/sbus_access.sv
// Single SBUS access sequencer: SETUP, STROBE, HOLD while start is held.
// Bus outputs are decoded from flops so reset removes a live strobe at once.
module sbus_access
    import sbus_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic        rd_nwr,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    phase_e phase_q, phase_d;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q <= PhSetup;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = PhSetup;
        if (start) begin
            unique case (phase_q)
                PhSetup:  phase_d = PhStrobe;
                PhStrobe: phase_d = PhHold;
                default:  phase_d = PhSetup;
            endcase
        end
    end

    // done marks the HOLD cycle; the master captures rdata on that cycle.
    always_comb begin
        saddress  = start ? addr : '0;
        sdata_out = (start && !rd_nwr) ? wdata : '0;
        srd       = start && rd_nwr && (phase_q == PhStrobe);
        swr       = start && !rd_nwr && (phase_q == PhStrobe);
        done      = start && (phase_q == PhHold);
        rdata     = sdata_in;
    end

endmodule

// File: rtl/sbus_mult_master.sv
// SBUS master: writes A1/A2, kicks CTRL, polls STAT, then reads W (and L).
// Macro SBUS_ONES_READ_EN enables the L read; without it rsp_l is constant 0.
module sbus_mult_master
    import sbus_pkg::*;
#(
    parameter int unsigned POLL_LIMIT = 1024,
    parameter int unsigned POLL_GAP   = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_err,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam int unsigned PollW = $clog2(POLL_LIMIT + 1);
    localparam int unsigned GapW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    state_e            state_q, state_d;
    logic [23:0]       a1_q, a1_d, a2_q, a2_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [PollW-1:0]  poll_q, poll_d, poll_inc;
    logic [31:0]       rsp_w_q, rsp_w_d;
    logic              rsp_err_q, rsp_err_d;
    logic              acc_start, acc_rd_nwr, acc_done;
    logic [15:0]       acc_addr;
    logic [31:0]       acc_wdata, acc_rdata;
`ifdef SBUS_ONES_READ_EN
    logic [23:0]       rsp_l_q, rsp_l_d;
`endif

    sbus_access u_access (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (acc_start),
        .rd_nwr    (acc_rd_nwr),
        .addr      (acc_addr),
        .wdata     (acc_wdata),
        .done      (acc_done),
        .rdata     (acc_rdata),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a1_q      <= '0;
            a2_q      <= '0;
            gap_q     <= '0;
            poll_q    <= '0;
            rsp_w_q   <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            a1_q      <= a1_d;
            a2_q      <= a2_d;
            gap_q     <= gap_d;
            poll_q    <= poll_d;
            rsp_w_q   <= rsp_w_d;
            rsp_err_q <= rsp_err_d;
        end
    end

`ifdef SBUS_ONES_READ_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rsp_l_q <= '0;
        end else begin
            rsp_l_q <= rsp_l_d;
        end
    end
    assign rsp_l = rsp_l_q;
`else
    assign rsp_l = '0;
`endif

    // Saturating increment: the counter parks at POLL_LIMIT instead of wrapping.
    assign poll_inc = (poll_q == PollW'(POLL_LIMIT)) ? poll_q : poll_q + PollW'(1);

    always_comb begin
        state_d   = state_q;
        a1_d      = a1_q;
        a2_d      = a2_q;
        gap_d     = '0;
        poll_d    = poll_q;
        rsp_w_d   = rsp_w_q;
        rsp_err_d = rsp_err_q;
`ifdef SBUS_ONES_READ_EN
        rsp_l_d   = rsp_l_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    a1_d      = cmd_a1;
                    a2_d      = cmd_a2;
                    poll_d    = '0;
                    rsp_w_d   = '0;
                    rsp_err_d = 1'b0;
`ifdef SBUS_ONES_READ_EN
                    rsp_l_d   = '0;
`endif
                    state_d   = StWrA1;
                end
            end
            StWrA1: if (acc_done) state_d = StWrA2;
            StWrA2: if (acc_done) state_d = StWrGo;
            StWrGo: if (acc_done) state_d = StGap;
            StGap: begin
                if (gap_q == GapW'(POLL_GAP - 1)) begin
                    state_d = StPoll;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StPoll: begin
                if (acc_done) begin
                    poll_d = poll_inc;
                    if (acc_rdata[1:0] != StatBusy) begin
                        state_d = StRdW;
                    end else if (poll_inc == PollW'(POLL_LIMIT)) begin
                        rsp_err_d = 1'b1;
                        rsp_w_d   = '0;
`ifdef SBUS_ONES_READ_EN
                        rsp_l_d   = '0;
`endif
                        state_d   = StDone;
                    end else begin
                        state_d = StGap;
                    end
                end
            end
            StRdW: begin
                if (acc_done) begin
                    rsp_w_d = acc_rdata;
`ifdef SBUS_ONES_READ_EN
                    state_d = StRdL;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef SBUS_ONES_READ_EN
            StRdL: begin
                if (acc_done) begin
                    rsp_l_d = acc_rdata[23:0];
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == StIdle);
        rsp_valid  = (state_q == StDone);
        acc_start  = 1'b0;
        acc_rd_nwr = 1'b0;
        acc_addr   = '0;
        acc_wdata  = '0;
        unique case (state_q)
            StWrA1: begin
                acc_start = 1'b1;
                acc_addr  = AddrA1;
                acc_wdata = {8'h00, a1_q};
            end
            StWrA2: begin
                acc_start = 1'b1;
                acc_addr  = AddrA2;
                acc_wdata = {8'h00, a2_q};
            end
            StWrGo: begin
                acc_start = 1'b1;
                acc_addr  = AddrCtrl;
            end
            StPoll: begin
                acc_start  = 1'b1;
                acc_rd_nwr = 1'b1;
                acc_addr   = AddrStat;
            end
            StRdW: begin
                acc_start  = 1'b1;
                acc_rd_nwr = 1'b1;
                acc_addr   = AddrW;
            end
`ifdef SBUS_ONES_READ_EN
            StRdL: begin
                acc_start  = 1'b1;
                acc_rd_nwr = 1'b1;
                acc_addr   = AddrL;
            end
`endif
            default: ;
        endcase
    end

    assign rsp_w   = rsp_w_q;
    assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_sbus_mult_master.sv
// Directed bench for sbus_mult_master with a strobe-driven peripheral model.
// Honours SBUS_ONES_READ_EN for the expected L read and latency.
module tb_sbus_mult_master;
    import sbus_pkg::*;

    localparam int unsigned Gap   = 4;
    localparam int unsigned Limit = 8;
`ifdef SBUS_ONES_READ_EN
    localparam bit LRead = 1'b1;
`else
    localparam bit LRead = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [23:0] cmd_a1 = '0;
    logic [23:0] cmd_a2 = '0;
    logic        cmd_ready, rsp_valid, rsp_err, srd, swr;
    logic [31:0] rsp_w, sdata_out;
    logic [23:0] rsp_l;
    logic [15:0] saddress;
    logic [31:0] sdata_in = '0;

    sbus_mult_master #(
        .POLL_LIMIT (Limit),
        .POLL_GAP   (Gap)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a1    (cmd_a1),
        .cmd_a2    (cmd_a2),
        .rsp_valid (rsp_valid),
        .rsp_w     (rsp_w),
        .rsp_l     (rsp_l),
        .rsp_err   (rsp_err),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in)
    );

    always #5 clk = ~clk;

    // Peripheral: answers a read at the end of its strobe, so data is valid in HOLD.
    int unsigned stat_total = 0;
    int unsigned stat_base  = 0;
    int unsigned per_busy   = 0;
    logic [31:0] per_w = '0, per_l = '0, per_done = 32'h1;

    always @(posedge clk) begin
        if (srd) begin
            if (saddress == AddrStat) begin
                sdata_in   <= (stat_total - stat_base < per_busy) ? 32'h5A5A_5A5B : per_done;
                stat_total <= stat_total + 1;
            end else if (saddress == AddrW) begin
                sdata_in <= per_w;
            end else if (saddress == AddrL) begin
                sdata_in <= per_l;
            end else begin
                sdata_in <= 32'hDEAD_BEEF;
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        int unsigned cyc;
    } acc_t;

    acc_t        log_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc_cnt  = 0;
    logic        prev_strobe = 1'b0;
    logic [15:0] hist1 = '0, hist2 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and run the bus protocol checks there.
    task automatic tick();
        acc_t e;
        @(negedge clk);
        cyc_cnt++;
        if (!n_reset) begin
            prev_strobe = 1'b0;
            hist1 = '0;
            hist2 = '0;
        end else begin
            check("srd_swr_excl", {31'h0, srd & swr}, 32'h0);
            if (srd | swr) begin
                check("strobe_width", {31'h0, prev_strobe}, 32'h0);
                e.wr   = swr;
                e.addr = saddress;
                e.data = swr ? sdata_out : 32'h0;
                e.cyc  = cyc_cnt;
                log_q.push_back(e);
            end
            if (prev_strobe) begin
                check("addr_hold", {16'h0, saddress}, {16'h0, hist1});
                check("addr_setup", {16'h0, hist2}, {16'h0, hist1});
            end
            hist2 = hist1;
            hist1 = saddress;
            prev_strobe = srd | swr;
        end
    endtask

    task automatic push_exp(inout acc_t q[$], input logic wr, input logic [15:0] addr,
                            input logic [31:0] data);
        acc_t e;
        e.wr = wr;
        e.addr = addr;
        e.data = data;
        e.cyc = 0;
        q.push_back(e);
    endtask

    task automatic run_job(input logic [23:0] a1, input logic [23:0] a2,
                           input int unsigned busy, input logic [31:0] stat_done,
                           input logic [31:0] w, input logic [31:0] l,
                           input bit hold, input string tag);
        acc_t        exp_q[$];
        int unsigned base, npolls, lat, exp_lat;
        bit          err;
        logic [31:0] exp_w, exp_l;
        err     = (busy >= Limit);
        npolls  = err ? Limit : busy + 1;
        exp_w   = err ? 32'h0 : w;
        exp_l   = (err || !LRead) ? 32'h0 : {8'h0, l[23:0]};
        exp_lat = 10 + npolls * (Gap + 3) + (err ? 0 : (LRead ? 6 : 3));
        push_exp(exp_q, 1'b1, AddrA1, {8'h0, a1});
        push_exp(exp_q, 1'b1, AddrA2, {8'h0, a2});
        push_exp(exp_q, 1'b1, AddrCtrl, 32'h0);
        for (int i = 0; i < int'(npolls); i++) push_exp(exp_q, 1'b0, AddrStat, 32'h0);
        if (!err) begin
            push_exp(exp_q, 1'b0, AddrW, 32'h0);
            if (LRead) push_exp(exp_q, 1'b0, AddrL, 32'h0);
        end

        per_busy  = busy;
        per_w     = w;
        per_l     = l;
        per_done  = stat_done;
        stat_base = stat_total;
        base      = log_q.size();
        cmd_a1    = a1;
        cmd_a2    = a2;
        cmd_valid = 1'b1;
        check({tag, ":ready"}, {31'h0, cmd_ready}, 32'h1);
        tick();
        lat    = 1;
        cmd_a1 = ~a1;
        cmd_a2 = ~a2;
        if (!hold) cmd_valid = 1'b0;
        while (!rsp_valid && lat < 400) begin
            check({tag, ":busy_ready"}, {31'h0, cmd_ready}, 32'h0);
            tick();
            lat++;
        end
        check({tag, ":latency"}, lat, exp_lat);
        check({tag, ":valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, ":done_ready"}, {31'h0, cmd_ready}, 32'h0);
        check({tag, ":rsp_w"}, rsp_w, exp_w);
        check({tag, ":rsp_l"}, {8'h0, rsp_l}, exp_l);
        check({tag, ":rsp_err"}, {31'h0, rsp_err}, {31'h0, err});
        tick();
        check({tag, ":valid_pulse"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, ":idle_ready"}, {31'h0, cmd_ready}, 32'h1);
        check({tag, ":w_hold"}, rsp_w, exp_w);
        check({tag, ":l_hold"}, {8'h0, rsp_l}, exp_l);
        check({tag, ":err_hold"}, {31'h0, rsp_err}, {31'h0, err});

        check({tag, ":n_acc"}, log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
            check({tag, ":acc_addr"}, {16'h0, log_q[base+i].addr}, {16'h0, exp_q[i].addr});
            check({tag, ":acc_dir"}, {31'h0, log_q[base+i].wr}, {31'h0, exp_q[i].wr});
            if (exp_q[i].wr) check({tag, ":acc_wdata"}, log_q[base+i].data, exp_q[i].data);
        end
        for (int k = 1; k < int'(npolls) && base + 3 + k < log_q.size(); k++) begin
            check({tag, ":poll_spacing"}, log_q[base+3+k].cyc - log_q[base+2+k].cyc, Gap + 3);
        end
    endtask

    initial begin
        int unsigned n;
        logic [31:0] r, ra, rb, rw, rl;

        #2 n_reset = 1'b0;
        #1;
        check("rst:cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst:rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst:rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst:rsp_w", rsp_w, 32'h0);
        check("rst:rsp_l", {8'h0, rsp_l}, 32'h0);
        check("rst:saddress", {16'h0, saddress}, 32'h0);
        check("rst:srd", {31'h0, srd}, 32'h0);
        check("rst:swr", {31'h0, swr}, 32'h0);
        check("rst:sdata_out", sdata_out, 32'h0);
        tick();
        tick();
        n_reset = 1'b1;
        tick();

        run_job(24'd5, 24'd3, 0, 32'h0000_0001, 32'h28, 32'h1, 1'b0, "nominal");
        tick();
        run_job(24'hABCDEF, 24'h123456, 5, 32'hFFFF_FFFC, 32'h1234_5678, 32'hAB00_0007,
                1'b0, "slow");
        run_job(24'h000001, 24'hFFFFFF, 7, 32'h0000_0002, 32'hCAFE_F00D, 32'h00FF_FFFF,
                1'b0, "last_poll_ok");
        run_job(24'h00000F, 24'h0000F0, 100, 32'h1, 32'h1111_1111, 32'h2222_2222,
                1'b0, "timeout");
        run_job(24'h000002, 24'h000004, 0, 32'h1, 32'h8, 32'h3, 1'b0, "after_timeout");

        // Abort a job in the STROBE cycle of the A2 write.
        per_busy  = 0;
        cmd_a1    = 24'h777777;
        cmd_a2    = 24'h888888;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(swr && saddress == AddrA2) && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid:a2_strobe_seen", {31'h0, swr}, 32'h1);
        n_reset = 1'b0;
        #1;
        check("rst_mid:swr", {31'h0, swr}, 32'h0);
        check("rst_mid:srd", {31'h0, srd}, 32'h0);
        check("rst_mid:saddress", {16'h0, saddress}, 32'h0);
        check("rst_mid:sdata_out", sdata_out, 32'h0);
        check("rst_mid:cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_mid:rsp_valid", {31'h0, rsp_valid}, 32'h0);
        tick();
        tick();
        n_reset = 1'b1;
        tick();
        check("rst_mid:ready_after", {31'h0, cmd_ready}, 32'h1);
        check("rst_mid:no_strobe", {31'h0, srd | swr}, 32'h0);
        run_job(24'd5, 24'd3, 0, 32'h1, 32'h28, 32'h1, 1'b0, "post_reset");

        // Back-to-back jobs with cmd_valid held high throughout.
        for (int j = 0; j < 100; j++) begin
            ra = $urandom;
            rb = $urandom;
            rw = $urandom;
            rl = $urandom;
            r  = $urandom;
            run_job(ra[23:0], rb[23:0], $urandom_range(0, 2),
                    {r[31:2], 2'($urandom_range(0, 2))}, rw, rl, 1'b1, "rand");
        end
        cmd_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
